scroll_text_engine: RTL and testbench

Parametrised column generator for scrolling-text LED/POV displays. Buffers a message of encoded words, then emits one display column per output handshake. Each word is either a raw column or a glyph index; glyph indices are expanded through an external font ROM into GLYPH_COLS columns. It adds an explicit load/play/abort flow, a message length counter, optional looping and ready/valid backpressure on the column output.

---
 rtl/scroll_text_engine_if.sv | 32 +++
 rtl/scroll_text_engine.sv | 195 +++++++++++++++++++
 tb/tb_scroll_text_engine.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/scroll_text_engine_if.sv
// Bus bundle for scroll_text_engine: word input stream, column output stream
// and the font ROM lookup port. The engine connects through the slave view
// and the surrounding system (host, display, font ROM) uses the master view.
interface scroll_text_engine_if #(
    parameter int WORD_W     = 7,
    parameter int GLYPH_COLS = 8,
    parameter int COL_W      = 8
) ();
    // word input stream
    logic                          in_valid;
    logic [WORD_W-1:0]             in_data;
    logic                          in_ready;
    // column output stream
    logic                          out_valid;
    logic                          out_ready;
    logic [COL_W-1:0]              out_col;
    logic                          out_last;
    // font ROM lookup (combinational ROM outside the engine)
    logic [WORD_W-2:0]             font_idx;
    logic [$clog2(GLYPH_COLS)-1:0] font_col;
    logic [COL_W-1:0]              font_data;

    modport slave (
        input  in_valid, in_data, out_ready, font_data,
        output in_ready, out_valid, out_col, out_last, font_idx, font_col
    );

    modport master (
        output in_valid, in_data, out_ready, font_data,
        input  in_ready, out_valid, out_col, out_last, font_idx, font_col
    );
endinterface

// File: rtl/scroll_text_engine.sv
// Scrolling-text column generator. Stores a message of encoded words while
// idle, then plays it out one display column per output handshake. Raw words
// produce a single column; glyph words are expanded through an external
// combinational font ROM into GLYPH_COLS columns.
module scroll_text_engine #(
    parameter int WORD_W     = 7,
    parameter int DEPTH      = 32,
    parameter int GLYPH_COLS = 8,
    parameter int COL_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    scroll_text_engine_if.slave    bus,
    input  logic                   clear,
    input  logic                   play,
    input  logic                   abort,
    input  logic                   loop_en,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int GC_W  = $clog2(GLYPH_COLS);

    localparam logic [CNT_W-1:0] LEN_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [GC_W-1:0]  COL_ONE  = GC_W'(1);
    localparam logic [GC_W-1:0]  COL_LAST = GC_W'(GLYPH_COLS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    // state
    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_len;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [GC_W-1:0]   r_col;
    logic              r_more;      // at least one column still to be loaded
    logic              r_out_valid;
    logic [COL_W-1:0]  r_out_col;
    logic              r_out_last;
    logic [WORD_W-1:0] r_buf [DEPTH];

    // combinational helpers
    logic              w_idle;
    logic              w_play;
    logic              w_in_ready;
    logic              w_wr;
    logic [CNT_W-1:0]  w_len_next;
    logic              w_start;
    logic [WORD_W-1:0] w_word;
    logic              w_is_glyph;
    logic              w_word_last_col;
    logic              w_msg_last_word;
    logic [COL_W-1:0]  w_raw_col;
    logic [COL_W-1:0]  w_col_val;
    logic              w_hs;
    logic              w_load;
    logic              w_done;
    logic              w_abort;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_play  = (r_state == ST_PLAY);

    // Writes are only taken while idle, not full and not being cleared.
    assign w_in_ready = w_idle & (r_len < LEN_FULL) & !clear;
    assign w_wr       = bus.in_valid & w_in_ready;

    // Length after this edge; clear wins over a same-cycle write.
    always_comb begin
        w_len_next = r_len;
        if (w_idle) begin
            if (clear) begin
                w_len_next = '0;
            end else if (w_wr) begin
                w_len_next = r_len + LEN_ONE;
            end
        end
    end

    // play counts a word written in the same cycle, so look at the next length
    assign w_start = w_idle & play & (w_len_next != '0);

    // Current word and its column value
    assign w_word          = r_buf[r_rd_ptr];
    assign w_is_glyph      = w_word[WORD_W-1];
    assign w_word_last_col = !w_is_glyph | (r_col == COL_LAST);
    assign w_msg_last_word = ({1'b0, r_rd_ptr} == (r_len - LEN_ONE));

    // Raw column is the 6-bit payload shifted left by one, zero-extended.
    genvar gi;
    generate
        for (gi = 0; gi < COL_W; gi++) begin : g_raw_col
            if (gi >= 1 && gi < WORD_W) begin : g_payload
                assign w_raw_col[gi] = w_word[gi-1];
            end else begin : g_zero
                assign w_raw_col[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_col_val = w_is_glyph ? bus.font_data : w_raw_col;

    // Output-side handshake, load and end-of-message conditions
    assign w_hs    = r_out_valid & bus.out_ready;
    assign w_abort = w_play & abort;
    assign w_load  = w_play & r_more & !abort & (!r_out_valid | bus.out_ready);
    assign w_done  = w_play & !r_more & w_hs;

    // Font ROM address follows the read position; parked at 0 when idle or raw.
    assign bus.font_idx = (w_play & w_is_glyph) ? w_word[WORD_W-2:0] : '0;
    assign bus.font_col = (w_play & w_is_glyph) ? r_col : '0;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_col   = r_out_col;
    assign bus.out_last  = r_out_last;
    assign count         = r_len;
    assign busy          = w_play;

    // IDLE/PLAY sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (w_start) begin
            r_state <= ST_PLAY;
        end else if (w_abort | w_done) begin
            r_state <= ST_IDLE;
        end
    end

    // Message length counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
        end else begin
            r_len <= w_len_next;
        end
    end

    // Message storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_len[PTR_W-1:0]] <= bus.in_data;
        end
    end

    // Read position: advances by one column on every output load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_col    <= '0;
            r_more   <= 1'b0;
        end else if (w_start) begin
            r_rd_ptr <= '0;
            r_col    <= '0;
            r_more   <= 1'b1;
        end else if (w_load) begin
            if (w_word_last_col) begin
                r_col <= '0;
                if (w_msg_last_word) begin
                    if (loop_en) begin
                        r_rd_ptr <= '0;
                    end else begin
                        r_more <= 1'b0;
                    end
                end else begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
            end else begin
                r_col <= r_col + COL_ONE;
            end
        end
    end

    // Output register: refills on a free slot, holds under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_col   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_abort) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_col   <= w_col_val;
            r_out_last  <= w_word_last_col & w_msg_last_word;
        end else if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_scroll_text_engine.sv
// Directed bench for scroll_text_engine: reset, raw/glyph playback,
// backpressure, fill/clear, looping with abort and reset during playback.
// Font model returns {font_idx[4:0], font_col}.
module tb_scroll_text_engine;
    localparam int WORD_W     = 7;
    localparam int DEPTH      = 32;
    localparam int GLYPH_COLS = 8;
    localparam int COL_W      = 8;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       play;
    logic       abort;
    logic       loop_en;
    logic [5:0] count;
    logic       busy;

    int total;
    int bad;

    scroll_text_engine_if #(
        .WORD_W(WORD_W), .GLYPH_COLS(GLYPH_COLS), .COL_W(COL_W)
    ) bus ();

    scroll_text_engine #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .GLYPH_COLS(GLYPH_COLS), .COL_W(COL_W)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .clear   (clear),
        .play    (play),
        .abort   (abort),
        .loop_en (loop_en),
        .count   (count),
        .busy    (busy)
    );

    assign bus.font_data = {bus.font_idx[4:0], bus.font_col};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        play  = 1'b0;
        abort = 1'b0;
        loop_en = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_col", bus.out_col, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_font_idx", bus.font_idx, 0);
        chk("rst_font_col", bus.font_col, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // play with an empty buffer does nothing
        play = 1'b1;
        step();
        play = 1'b0;
        chk("empty_play_busy", busy, 0);
        step();
        chk("empty_play_busy2", busy, 0);

        // raw 15 then glyph 41, single pass
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h15;
        step();
        chk("wr1_count", count, 1);
        bus.in_data = 7'h41;
        step();
        chk("wr2_count", count, 2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        play = 1'b1;
        step();
        play = 1'b0;
        chk("play_busy", busy, 1);
        chk("play_lat_valid", bus.out_valid, 0);
        step();
        chk("raw_valid", bus.out_valid, 1);
        chk("raw_col", bus.out_col, 8'h2A);
        chk("raw_last", bus.out_last, 0);
        chk("glyph_font_idx", bus.font_idx, 1);
        chk("glyph_font_col", bus.font_col, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("glyph_valid", bus.out_valid, 1);
            chk("glyph_col", bus.out_col, 32'h08 + k);
            chk("glyph_last", bus.out_last, (k == 7) ? 1 : 0);
        end
        step();
        chk("end_busy", busy, 0);
        chk("end_valid", bus.out_valid, 0);
        chk("end_in_ready", bus.in_ready, 1);

        // backpressure mid-glyph
        play = 1'b1;
        step();
        play = 1'b0;
        step();
        chk("bp_raw_col", bus.out_col, 8'h2A);
        step();
        chk("bp_col0", bus.out_col, 8'h08);
        step();
        chk("bp_col1", bus.out_col, 8'h09);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_col", bus.out_col, 8'h09);
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_font_col", bus.font_col, 2);
        end
        bus.out_ready = 1'b1;
        for (int k = 2; k < 8; k++) begin
            step();
            chk("bp_resume_col", bus.out_col, 32'h08 + k);
            chk("bp_resume_last", bus.out_last, (k == 7) ? 1 : 0);
        end
        step();
        chk("bp_end_busy", busy, 0);

        // loop with abort
        clear = 1'b1;
        #1;
        chk("clear_in_ready", bus.in_ready, 0);
        step();
        clear = 1'b0;
        chk("clear_count", count, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h01;
        step();
        bus.in_data = 7'h02;
        step();
        bus.in_valid = 1'b0;
        chk("loop_count", count, 2);
        loop_en = 1'b1;
        play = 1'b1;
        step();
        play = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("loop_col", bus.out_col, (k % 2 == 0) ? 32'h02 : 32'h04);
            chk("loop_last", bus.out_last, (k % 2 == 0) ? 0 : 1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_last", bus.out_last, 0);
        chk("abort_busy", busy, 0);

        // clear beats a same-cycle write, then fill past DEPTH
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h3F;
        #1;
        chk("clrwr_in_ready", bus.in_ready, 0);
        step();
        clear = 1'b0;
        chk("clrwr_count", count, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.in_data = 7'(i & 63);
            step();
        end
        bus.in_valid = 1'b0;
        chk("full_count", count, DEPTH);
        chk("full_in_ready", bus.in_ready, 0);
        loop_en = 1'b0;
        play = 1'b1;
        step();
        play = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("fill_col", bus.out_col, 2 * i);
            chk("fill_last", bus.out_last, (i == DEPTH - 1) ? 1 : 0);
        end
        step();
        chk("fill_end_busy", busy, 0);
        chk("fill_end_in_ready", bus.in_ready, 0);

        // asynchronous reset during playback
        loop_en = 1'b1;
        play = 1'b1;
        step();
        play = 1'b0;
        step();
        step();
        chk("prerst_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_col", bus.out_col, 0);
        chk("arst_busy", busy, 0);
        chk("arst_count", count, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_count", count, 0);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_valid", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
